// File: rtl/rsign_array_if.sv
// Window stream (in) and binarised sign stream (out) between a producer and rsign_array.
`timescale 1ns/1ps
interface rsign_array_if #(
  parameter int FM_DEPTH  = 64,
  parameter int CORE_SIZE = 9,
  parameter int DATA_W    = 16
);
  logic                               data_in_valid;
  logic                               data_in_ready;
  logic [FM_DEPTH*CORE_SIZE*DATA_W-1:0] data_in;
  logic                               data_out_valid;
  logic                               data_out_ready;
  logic [FM_DEPTH*CORE_SIZE-1:0]        data_out;

  modport master (
    output data_in_valid, data_in, data_out_ready,
    input  data_in_ready, data_out_valid, data_out
  );

  modport slave (
    input  data_in_valid, data_in, data_out_ready,
    output data_in_ready, data_out_valid, data_out
  );
endinterface

// File: rtl/rsign_array.sv
// Per-channel signed threshold binariser: out[c][k] = (in[c][k] > thresh[c]), one-cycle latency.
// Optional RSIGN_ARRAY_DBLBUF_EN: shadow threshold bank loadable in any state, committed after the last channel.
`timescale 1ns/1ps
module rsign_array #(
  parameter int FM_DEPTH  = 64,
  parameter int CORE_SIZE = 9,
  parameter int DATA_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_in,
  input  logic                     para_valid,
  input  logic signed [DATA_W-1:0] para_in,
  output logic                     para_loaded,
  rsign_array_if.slave             bus
);

  localparam int CNT_W = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
  localparam int NBITS = FM_DEPTH * CORE_SIZE;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(FM_DEPTH - 1);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             para_loaded_reg;
  logic             out_valid_reg;
  logic [NBITS-1:0] out_data_reg;
  logic [NBITS-1:0] cmp_bits;
  logic             accept, load_entry, para_wr, last_wr;

  logic signed [DATA_W-1:0] thresh_mem [FM_DEPTH];

  always_comb begin
    state_next = ST_WAIT;
    if (!mode_in)
      state_next = ST_LOAD;
    else if (para_loaded_reg)
      state_next = ST_RUN;
  end

  assign load_entry = (state_reg != ST_LOAD) && !mode_in;
`ifdef RSIGN_ARRAY_DBLBUF_EN
  assign para_wr = para_valid && !load_entry;
`else
  assign para_wr = para_valid && (state_reg == ST_LOAD);
`endif
  assign last_wr = para_wr && (cnt_reg == LAST_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_WAIT;
      cnt_reg         <= '0;
      para_loaded_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_entry) begin
        cnt_reg         <= '0;
        para_loaded_reg <= 1'b0;
      end else if (para_wr) begin
        cnt_reg <= last_wr ? '0 : cnt_reg + CNT_W'(1);
        if (last_wr)
          para_loaded_reg <= 1'b1;
      end
    end
  end

  assign para_loaded = para_loaded_reg;

`ifdef RSIGN_ARRAY_DBLBUF_EN
  // Commit lands one cycle after the last-channel write, so beats accepted
  // in that write cycle and in the commit cycle still see the old bank.
  logic signed [DATA_W-1:0] shadow_mem [FM_DEPTH];
  logic                     commit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      commit_reg <= 1'b0;
    else
      commit_reg <= last_wr && !load_entry;
  end

  always_ff @(posedge clk) begin
    if (para_wr)
      shadow_mem[cnt_reg] <= para_in;
    if (commit_reg)
      for (int i = 0; i < FM_DEPTH; i++)
        thresh_mem[i] <= shadow_mem[i];
  end
`else
  always_ff @(posedge clk) begin
    if (para_wr)
      thresh_mem[cnt_reg] <= para_in;
  end
`endif

  genvar gi, gk;
  generate
    for (gi = 0; gi < FM_DEPTH; gi++) begin : g_ch
      for (gk = 0; gk < CORE_SIZE; gk++) begin : g_el
        assign cmp_bits[gi*CORE_SIZE+gk] =
          $signed(bus.data_in[(gi*CORE_SIZE+gk)*DATA_W +: DATA_W]) > thresh_mem[gi];
      end
    end
  endgenerate

  assign bus.data_in_ready = (state_reg == ST_RUN) && (!out_valid_reg || bus.data_out_ready);
  assign accept            = bus.data_in_valid && bus.data_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= cmp_bits;
    end else if (bus.data_out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.data_out_valid = out_valid_reg;
  assign bus.data_out       = out_data_reg;

endmodule

// File: tb/tb_rsign_array.sv
// Bench for rsign_array (2 channels x 2 elements): vector table, scoreboard, and corner-case sequences.
`timescale 1ns/1ps
module tb_rsign_array;
  localparam int FD = 2;
  localparam int CS = 2;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 mode_in = 1'b0;
  logic                 para_valid = 1'b0;
  logic signed [DW-1:0] para_in = '0;
  logic                 para_loaded;

  rsign_array_if #(.FM_DEPTH(FD), .CORE_SIZE(CS), .DATA_W(DW)) bus();

  rsign_array #(.FM_DEPTH(FD), .CORE_SIZE(CS), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_in     (mode_in),
    .para_valid  (para_valid),
    .para_in     (para_in),
    .para_loaded (para_loaded),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e0, e1, e2, e3;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl [8];
  int         tests_run = 0;
  int         fails = 0;
  int         pops = 0;
  int         exp_beats = 0;
  logic [3:0] cur_exp = '0;
  logic [3:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FD*CS*DW-1:0] pack(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_thr(input int t0, input int t1);
    mode_in = 1'b0;
    tick();
    para_valid = 1'b1;
    para_in    = t0[DW-1:0];
    tick();
    para_in    = t1[DW-1:0];
    tick();
    para_valid = 1'b0;
  endtask

  // Scoreboard: drain first (older beat), then record the beat being accepted.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.data_out_valid && bus.data_out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL sb_extra: got output %0h, expected no output", bus.data_out);
        end else begin
          check("sb_order", 64'(bus.data_out), 64'(sb.pop_front()));
        end
      end
      if (bus.data_in_valid && bus.data_in_ready)
        sb.push_back(cur_exp);
    end
  end

  initial begin
    tbl[0] = '{6, 5, -3, -2, 4'b1001};
    tbl[1] = '{-32768, 32767, -32768, 32767, 4'b1010};
    tbl[2] = '{5, 5, -3, -3, 4'b0000};
    tbl[3] = '{6, 6, -2, -2, 4'b1111};
    tbl[4] = '{100, 4, 0, -4, 4'b0101};
    tbl[5] = '{-1, 7, -3, -32768, 4'b0010};
    tbl[6] = '{32767, -32768, 32767, -2, 4'b1101};
    tbl[7] = '{0, 0, 0, 0, 4'b1100};

    bus.data_in_valid  = 1'b0;
    bus.data_in        = '0;
    bus.data_out_ready = 1'b1;

    repeat (3) tick();
    check("rst_loaded", 64'(para_loaded), 0);
    check("rst_valid", 64'(bus.data_out_valid), 0);
    check("rst_data", 64'(bus.data_out), 0);
    check("rst_ready", 64'(bus.data_in_ready), 0);
    rst = 1'b0;
    tick();

    // Partial load: one of two thresholds, then calculate mode
    mode_in = 1'b0;
    tick();
    para_valid = 1'b1;
    para_in    = 16'sd5;
    tick();
    para_valid        = 1'b0;
    mode_in           = 1'b1;
    bus.data_in_valid = 1'b1;
    bus.data_in       = pack(6, 5, -3, -2);
    repeat (10) begin
      tick();
      check("partial_loaded", 64'(para_loaded), 0);
      check("partial_ready", 64'(bus.data_in_ready), 0);
    end
    bus.data_in_valid = 1'b0;

    load_thr(5, -3);
    check("full_loaded", 64'(para_loaded), 1);
    mode_in = 1'b1;
    tick();
    check("run_ready", 64'(bus.data_in_ready), 1);

    // Table: back-to-back beats, one output per cycle
    for (int i = 0; i < 8; i++) begin
      bus.data_in       = pack(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
      cur_exp           = tbl[i].exp;
      bus.data_in_valid = 1'b1;
      check($sformatf("vec%0d_ready", i), 64'(bus.data_in_ready), 1);
      exp_beats++;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.data_out_valid), 1);
      check($sformatf("vec%0d_data", i), 64'(bus.data_out), 64'(tbl[i].exp));
    end
    bus.data_in_valid = 1'b0;
    tick();
    check("idle_valid", 64'(bus.data_out_valid), 0);

    // Backpressure: held output, second beat never accepted
    bus.data_out_ready = 1'b0;
    bus.data_in        = pack(100, 4, 0, -4);
    cur_exp            = 4'b0101;
    bus.data_in_valid  = 1'b1;
    exp_beats++;
    tick();
    check("bp_valid0", 64'(bus.data_out_valid), 1);
    bus.data_in = pack(6, 6, -2, -2);
    cur_exp     = 4'b1111;
    repeat (3) begin
      check("bp_ready", 64'(bus.data_in_ready), 0);
      tick();
      check("bp_hold_data", 64'(bus.data_out), 64'(4'b0101));
      check("bp_hold_valid", 64'(bus.data_out_valid), 1);
    end
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    tick();
    check("bp_drained", 64'(bus.data_out_valid), 0);

`ifndef RSIGN_ARRAY_DBLBUF_EN
    // Threshold beats during RUN must not touch the bank
    para_valid = 1'b1;
    para_in    = -16'sd32768;
    repeat (2) tick();
    para_valid        = 1'b0;
    bus.data_in       = pack(4, 100, -4, 0);
    cur_exp           = 4'b1010;
    bus.data_in_valid = 1'b1;
    exp_beats++;
    tick();
    bus.data_in_valid = 1'b0;
    check("ignore_para", 64'(bus.data_out), 64'(4'b1010));
    check("ignore_loaded", 64'(para_loaded), 1);
    tick();
`endif

    // Mode falls with an output pending
    bus.data_out_ready = 1'b0;
    bus.data_in        = pack(6, 5, -3, -2);
    cur_exp            = 4'b1001;
    bus.data_in_valid  = 1'b1;
    exp_beats++;
    tick();
    bus.data_in_valid = 1'b0;
    mode_in           = 1'b0;
    repeat (2) begin
      tick();
      check("mfall_valid", 64'(bus.data_out_valid), 1);
      check("mfall_data", 64'(bus.data_out), 64'(4'b1001));
      check("mfall_ready", 64'(bus.data_in_ready), 0);
    end
    check("mfall_loaded", 64'(para_loaded), 0);
    bus.data_out_ready = 1'b1;
    tick();
    check("mfall_drained", 64'(bus.data_out_valid), 0);

    // Extreme thresholds, including equality at both ends of the range
    para_valid = 1'b1;
    para_in    = -16'sd32768;
    tick();
    para_in = 16'sd32767;
    tick();
    para_valid = 1'b0;
    check("ext_loaded", 64'(para_loaded), 1);
    mode_in = 1'b1;
    tick();
    bus.data_in       = pack(-32767, -32768, 32767, 32766);
    cur_exp           = 4'b0001;
    bus.data_in_valid = 1'b1;
    exp_beats++;
    tick();
    bus.data_in_valid = 1'b0;
    check("ext_data", 64'(bus.data_out), 64'(4'b0001));
    tick();

    // Asynchronous reset with an output pending
    bus.data_out_ready = 1'b0;
    bus.data_in        = pack(6, 6, -2, -2);
    cur_exp            = 4'b0011;
    bus.data_in_valid  = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.data_out_valid), 1);
    check("pre_rst_data", 64'(bus.data_out), 64'(4'b0011));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.data_out_valid), 0);
    check("arst_data", 64'(bus.data_out), 0);
    check("arst_ready", 64'(bus.data_in_ready), 0);
    check("arst_loaded", 64'(para_loaded), 0);
    tick();
    rst                = 1'b0;
    bus.data_out_ready = 1'b1;
    repeat (4) tick();
    check("post_rst_ready", 64'(bus.data_in_ready), 0);
    check("post_rst_valid", 64'(bus.data_out_valid), 0);

`ifdef RSIGN_ARRAY_DBLBUF_EN
    // Reload channel 0 from 5 to 10 while streaming value 7
    load_thr(5, -3);
    mode_in = 1'b1;
    tick();
    bus.data_in       = pack(7, 0, 0, 0);
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      para_valid = (i == 1) || (i == 2);
      para_in    = (i == 1) ? 16'sd10 : -16'sd3;
      cur_exp    = (i < 4) ? 4'b1101 : 4'b1100;
      check($sformatf("dbl%0d_ready", i), 64'(bus.data_in_ready), 1);
      exp_beats++;
      tick();
      check($sformatf("dbl%0d_data", i), 64'(bus.data_out), 64'(cur_exp));
    end
    para_valid        = 1'b0;
    bus.data_in_valid = 1'b0;
    tick();
`endif

    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 0);
    check("sb_count", 64'(pops), 64'(exp_beats));
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
